// File: rtl/scan_decoder_pkg.sv
// Shared types and sizing helpers for the LED-matrix line decoder/scanner.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Dwell/blank counter width: holds max(DWELL, BLANK) remaining-cycle values.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_decoder_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable; all-zero when disabled.
module decoder_onehot #(
  parameter int N = 3
) (
  input  logic              ena,
  input  logic [N-1:0]      in,
  output logic [(1<<N)-1:0] out
);

  localparam int W = 1 << N;

  // One compare per output line keeps the result provably one-hot.
  for (genvar i = 0; i < W; i++) begin : g_line
    assign out[i] = ena && (in == N'(i));
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot line decoder with an autonomous line scanner (dwell + blanking gap).
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              mode,
  input  logic [N-1:0]      in,
  input  logic              start,
  input  logic              cont,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      index,
  output logic              busy,
  output logic              frame_done
);

  localparam int W  = 1 << N;
  localparam int CW = cnt_width(DWELL, BLANK);
  // Counters hold "cycles remaining after this one", so loads are length-1.
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [N-1:0]  MAX_IDX  = {N{1'b1}};

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  index_q, index_d;
  logic [W-1:0]  out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          eol;
  logic          dec_ena;
  logic [N-1:0]  dec_in;

  decoder_onehot #(.N(N)) u_dec (
    .ena (dec_ena),
    .in  (dec_in),
    .out (out_d)
  );

  // Next-state: direct decode overrides scanning; ena low freezes scan state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    done_d  = 1'b0;
    eol     = 1'b0;
    dec_ena = 1'b0;
    dec_in  = index_q;
    if (!mode) begin
      // Also aborts a running frame with no frame_done.
      state_d = IDLE;
      cnt_d   = '0;
      index_d = in;
      dec_in  = in;
      dec_ena = ena;
    end else begin
      case (state_q)
        IDLE: begin
          if (ena && start) begin
            state_d = LINE;
            index_d = '0;
            cnt_d   = DWELL_LD;
          end
        end
        LINE: begin
          if (ena) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (BLANK > 0) begin
              state_d = GAP;
              cnt_d   = BLANK_LD;
            end else begin
              eol = 1'b1;
            end
          end
        end
        GAP: begin
          if (ena) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             eol   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (eol) begin
        if (index_q != MAX_IDX) begin
          index_d = index_q + 1'b1;
          state_d = LINE;
          cnt_d   = DWELL_LD;
        end else begin
          done_d = 1'b1;
          if (cont) begin
            index_d = '0;
            state_d = LINE;
            cnt_d   = DWELL_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      // Drive a line only when the next state is LINE and we are enabled.
      dec_in  = index_d;
      dec_ena = ena && (state_d == LINE);
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out        = out_q;
  assign index      = index_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
